// File: rtl/ifetch_buffer.sv
// ---------------------------------------------------------------------------
// ifetch_buffer
//
// Instruction fetch buffer sitting between the fetch-bus response path and
// the aligner. It is a circular FIFO of DEPTH entries. Each entry holds
// {err[2:0], skip, pred[1:0], data[31:0]}.
//
// The head entry is presented to the aligner as an info/instr/pred triple.
// The head is popped on every cycle in which the aligner does not stall.
//
// Optional feature (macro IFB_BYPASS_EN):
//   When IFB_BYPASS_EN is defined and the buffer is empty, an incoming write
//   drives the outputs combinationally in the same cycle.
//   - If the aligner is not stalling, that word is consumed immediately and
//     is never stored.
//   - If the aligner is stalling, the word is stored normally.
//   When IFB_BYPASS_EN is undefined, a write reaches the outputs one cycle
//   after it is accepted, at the earliest.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   CW     occupancy counter width (derived, do not override)
//
// Ports:
//   s_clk_i     clock
//   s_resetn_i  asynchronous active-low reset
//   s_flush_i   synchronous flush; drops every entry
//   s_wvalid_i  fetch response valid
//   s_wdata_i   fetched word
//   s_werr_i    fetch error code
//   s_wskip_i   lower halfword not part of the instruction stream
//   s_wpred_i   prediction marks: [0] from lower half, [1] from upper half
//   s_wready_o  buffer not full (from registered occupancy only)
//   s_stall_i   aligner stall; the head is popped only when this is low
//   s_info_o    [0] nop, [1] lower half invalid, [4:2] fetch error
//   s_instr_o   head word
//   s_pred_o    head prediction marks
//   s_occ_o     number of valid entries
//   s_ovf_o     one-cycle pulse after a write was dropped because the
//               buffer was full
// ---------------------------------------------------------------------------
module ifetch_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          s_clk_i,
    input  logic          s_resetn_i,
    input  logic          s_flush_i,
    input  logic          s_wvalid_i,
    input  logic [31:0]   s_wdata_i,
    input  logic [2:0]    s_werr_i,
    input  logic          s_wskip_i,
    input  logic [1:0]    s_wpred_i,
    output logic          s_wready_o,
    input  logic          s_stall_i,
    output logic [4:0]    s_info_o,
    output logic [31:0]   s_instr_o,
    output logic [1:0]    s_pred_o,
    output logic [CW-1:0] s_occ_o,
    output logic          s_ovf_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);
    localparam logic [4:0]    INFO_NOP = 5'b00001;

    // Entry storage. The storage arrays are deliberately not reset.
    // Entries are only ever read when the occupancy says they were written.
    logic [31:0]   mem_data [DEPTH];
    logic [2:0]    mem_err  [DEPTH];
    logic          mem_skip [DEPTH];
    logic [1:0]    mem_pred [DEPTH];

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] occ;
    logic          ovf;

    logic          full;
    logic          hv;
    logic          push;
    logic          pop;
    logic          bypass_hit;
    logic          bypass_take;

    assign full = (occ == OCC_FULL);
    assign hv   = (occ != '0);

`ifdef IFB_BYPASS_EN
    // The write port feeds the outputs only while the buffer is empty.
    // If the aligner takes the word in that same cycle, it is never stored.
    assign bypass_hit  = ~hv & s_wvalid_i & ~s_flush_i;
    assign bypass_take = bypass_hit & ~s_stall_i;
`else
    assign bypass_hit  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    // A pop in the same cycle does not free a slot for a write.
    // The write is gated by the registered full flag only.
    assign push = s_wvalid_i & ~full & ~s_flush_i & ~bypass_take;
    assign pop  = hv & ~s_stall_i & ~s_flush_i;

    // Pointers and occupancy
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else if (s_flush_i) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    // Overflow is reported only for writes that were rejected because the
    // buffer was full. A write dropped by a flush does not raise it.
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            ovf <= 1'b0;
        end else begin
            ovf <= s_wvalid_i & full & ~s_flush_i;
        end
    end

    // Storage write
    always_ff @(posedge s_clk_i) begin
        if (push) begin
            mem_data[wp] <= s_wdata_i;
            mem_err[wp]  <= s_werr_i;
            mem_skip[wp] <= s_wskip_i;
            mem_pred[wp] <= s_wpred_i;
        end
    end

    // Head presentation. With no valid head, the outputs show a nop.
    always_comb begin
        s_info_o  = INFO_NOP;
        s_instr_o = '0;
        s_pred_o  = '0;
        if (bypass_hit) begin
            s_info_o  = {s_werr_i, s_wskip_i, 1'b0};
            s_instr_o = s_wdata_i;
            s_pred_o  = s_wpred_i;
        end else if (hv) begin
            s_info_o  = {mem_err[rp], mem_skip[rp], 1'b0};
            s_instr_o = mem_data[rp];
            s_pred_o  = mem_pred[rp];
        end
    end

    assign s_wready_o = ~full;
    assign s_occ_o    = occ;
    assign s_ovf_o    = ovf;

endmodule

// File: tb/tb_ifetch_buffer.sv
module tb_ifetch_buffer;

    localparam int         DEPTH       = 4;
    localparam int         CW          = $clog2(DEPTH) + 1;
    localparam logic [2:0] FETCH_VALID = 3'b000;

    typedef struct packed {
        logic [2:0]  err;
        logic        skip;
        logic [1:0]  pred;
        logic [31:0] data;
    } ent_t;

    logic          s_clk_i;
    logic          s_resetn_i;
    logic          s_flush_i;
    logic          s_wvalid_i;
    logic [31:0]   s_wdata_i;
    logic [2:0]    s_werr_i;
    logic          s_wskip_i;
    logic [1:0]    s_wpred_i;
    logic          s_wready_o;
    logic          s_stall_i;
    logic [4:0]    s_info_o;
    logic [31:0]   s_instr_o;
    logic [1:0]    s_pred_o;
    logic [CW-1:0] s_occ_o;
    logic          s_ovf_o;

    ifetch_buffer #(.DEPTH(DEPTH)) dut (
        .s_clk_i    (s_clk_i),
        .s_resetn_i (s_resetn_i),
        .s_flush_i  (s_flush_i),
        .s_wvalid_i (s_wvalid_i),
        .s_wdata_i  (s_wdata_i),
        .s_werr_i   (s_werr_i),
        .s_wskip_i  (s_wskip_i),
        .s_wpred_i  (s_wpred_i),
        .s_wready_o (s_wready_o),
        .s_stall_i  (s_stall_i),
        .s_info_o   (s_info_o),
        .s_instr_o  (s_instr_o),
        .s_pred_o   (s_pred_o),
        .s_occ_o    (s_occ_o),
        .s_ovf_o    (s_ovf_o)
    );

    initial s_clk_i = 1'b0;
    always #5 s_clk_i = ~s_clk_i;

    // Reference model: the FIFO contents are held as a queue of entries.
    // m_occ and m_ovf are the expected occupancy and overflow flag.
    ent_t sb[$];
    int   m_occ    = 0;
    logic m_ovf    = 1'b0;
    logic mon_en   = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented head against the front of the queue.
    // It consumes the front entry whenever the aligner is not stalling.
    always @(negedge s_clk_i) begin
        if (mon_en) begin
            chk("occ", 64'(s_occ_o), 64'(m_occ));
            chk("wready", 64'(s_wready_o), 64'(m_occ != DEPTH));
            chk("ovf", 64'(s_ovf_o), 64'(m_ovf));
            chk("head_present", 64'(!s_info_o[0]), 64'(sb.size() != 0));
            if (!s_info_o[0] && sb.size() != 0) begin
                chk("info", 64'(s_info_o), 64'({sb[0].err, sb[0].skip, 1'b0}));
                chk("instr", 64'(s_instr_o), 64'(sb[0].data));
                chk("pred", 64'(s_pred_o), 64'(sb[0].pred));
                if (!s_stall_i && !s_flush_i) begin
                    void'(sb.pop_front());
                end
            end else if (s_info_o[0] && sb.size() == 0) begin
                chk("nop_outputs", 64'({s_info_o, s_instr_o, s_pred_o}),
                    64'({5'b00001, 32'h0, 2'b00}));
            end
        end
    end

    // Drives one cycle of stimulus and advances the model.
    task automatic step(input logic wv, input logic [31:0] d, input logic [2:0] er,
                        input logic sk, input logic [1:0] pr, input logic st,
                        input logic fl);
        ent_t e;
        logic empty;
        logic accept;
        logic popm;
        logic consumed;
        int   nocc;
        logic novf;
        e = {er, sk, pr, d};
        s_wvalid_i = wv;
        s_wdata_i  = d;
        s_werr_i   = er;
        s_wskip_i  = sk;
        s_wpred_i  = pr;
        s_stall_i  = st;
        s_flush_i  = fl;
        empty  = (m_occ == 0);
        accept = wv && !fl && (m_occ != DEPTH);
        popm   = !empty && !st && !fl;
`ifdef IFB_BYPASS_EN
        consumed = accept && empty && !st;
        if (accept) sb.push_back(e);
`else
        consumed = 1'b0;
`endif
        nocc = m_occ + ((accept && !consumed) ? 1 : 0) - (popm ? 1 : 0);
        novf = wv && !fl && (m_occ == DEPTH);
        @(posedge s_clk_i);
        #1;
        if (fl) begin
            sb.delete();
            m_occ = 0;
        end else begin
            m_occ = nocc;
        end
`ifndef IFB_BYPASS_EN
        if (accept) sb.push_back(e);
`endif
        m_ovf = novf;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_resetn_i = 1'b0;
        s_flush_i  = 1'b0;
        s_wvalid_i = 1'b0;
        s_wdata_i  = '0;
        s_werr_i   = '0;
        s_wskip_i  = 1'b0;
        s_wpred_i  = '0;
        s_stall_i  = 1'b0;
        repeat (2) @(posedge s_clk_i);
        #1;
        s_resetn_i = 1'b1;
        mon_en     = 1'b1;
        idle(2);

        // Single word, no stall
        step(1'b1, 32'h00A2_0513, FETCH_VALID, 1'b0, 2'b00, 1'b0, 1'b0);
        idle(3);

        // Fill under stall, fifth write overflows
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h1000_0000 + i, 3'(i), 1'b0, 2'(i), 1'b1, 1'b0);
        step(1'b0, 32'h0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(6);

        // Skip with prediction from the upper half and an error code
        step(1'b1, 32'hDEAD_BEEF, 3'b010, 1'b1, 2'b10, 1'b0, 1'b0);
        idle(2);

        // Three held entries, then a flush that collides with a write
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h2000_0000 + i, 3'b000, 1'b0, 2'b01, 1'b1, 1'b0);
        step(1'b1, 32'hBAD0_0000, 3'b001, 1'b0, 2'b00, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 9; i++)
            step(1'b1, 32'h3000_0000 + i, 3'(i), i[0], 2'(i), 1'b0, 1'b0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end
        idle(DEPTH + 2);
        chk("drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
